// File: rtl/stage_ex.sv
// Execute stage: operand-2 barrel shift, ALU, condition check against the
// registered CPSR, flag update, branch resolution with front-end flush and
// squash of younger instructions, and result registers for mem/writeback.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   stall_in              freeze every register (outputs, CPSR, squash count)
//   rn/rm/rd_in           register operands from decode
//   bypass_rm_in          pre-rotated immediate, used when should_bypass_rm_in
//   shiftcode/shiftby_in  LSL/LSR/ASR/ROR and amount applied to rm
//   alu_opcode_in         ARM data-processing opcode
//   should_set_cpsr_in    per-flag update enable {N,Z,C,V}
//   cond_in               ARM condition field
//   ib/bl/bv/pc_in        branch, branch-with-link, offset, instruction address
//   wa/reg_we/mem_we/should_bypass_data/is_invalid_in  decode control
//   result_out            ALU result, or pc+4 for BL
//   store_data_out        rd operand for stores
//   wa_out, reg_we_out, mem_we_out, should_bypass_data_out
//   flush_out             taken branch, one-cycle pulse
//   branch_target_out     pc+8+bv
//   cpsr_out              current {N,Z,C,V}
module stage_ex #(
  parameter int unsigned FULLW    = 32,
  parameter int unsigned REGAW    = 4,
  parameter int unsigned SQUASH_N = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_in,
  input  logic [FULLW-1:0] rn_in,
  input  logic [FULLW-1:0] rm_in,
  input  logic [FULLW-1:0] rd_in,
  input  logic [FULLW-1:0] bypass_rm_in,
  input  logic             should_bypass_rm_in,
  input  logic [1:0]       shiftcode_in,
  input  logic [4:0]       shiftby_in,
  input  logic [3:0]       alu_opcode_in,
  input  logic [3:0]       should_set_cpsr_in,
  input  logic [3:0]       cond_in,
  input  logic             ib_in,
  input  logic             bl_in,
  input  logic [FULLW-1:0] bv_in,
  input  logic [FULLW-1:0] pc_in,
  input  logic [REGAW-1:0] wa_in,
  input  logic             reg_we_in,
  input  logic             mem_we_in,
  input  logic             should_bypass_data_in,
  input  logic             is_invalid_in,
  output logic [FULLW-1:0] result_out,
  output logic [FULLW-1:0] store_data_out,
  output logic [REGAW-1:0] wa_out,
  output logic             reg_we_out,
  output logic             mem_we_out,
  output logic             should_bypass_data_out,
  output logic             flush_out,
  output logic [FULLW-1:0] branch_target_out,
  output logic [3:0]       cpsr_out
);

  localparam int unsigned CNTW = 2;
  localparam int unsigned FN   = 3;
  localparam int unsigned FZ   = 2;
  localparam int unsigned FC   = 1;
  localparam int unsigned FV   = 0;
  localparam int unsigned MSB  = FULLW - 1;
  localparam logic [REGAW-1:0] LINK_REG = REGAW'(14);

  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA;
  localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

  logic [FULLW-1:0] result_q, store_data_q, target_q;
  logic [REGAW-1:0] wa_q;
  logic             reg_we_q, mem_we_q, byp_q, flush_q;
  logic [3:0]       cpsr_q;
  logic [CNTW-1:0]  cnt_q;

  logic [FULLW-1:0] result_d, target_d;
  logic [REGAW-1:0] wa_d;
  logic             reg_we_d, mem_we_d, flush_d;
  logic [3:0]       cpsr_d;
  logic [CNTW-1:0]  cnt_d;

  logic             cond_pass, live;
  logic [FULLW-1:0] op2, ror_v;
  logic             sh_c;
  logic [FULLW:0]   lsl_w, lsr_w;
  logic signed [FULLW:0] asr_w;
  logic [FULLW-1:0] add_a, add_b, alu_res;
  logic             add_cin, add_v, alu_c, alu_v, is_test;
  logic [FULLW:0]   sum;
  logic [3:0]       flags_new;

  // Condition evaluation uses the registered flags only
  always_comb begin
    cond_pass = 1'b0;
    case (cond_in)
      4'h0: cond_pass = cpsr_q[FZ];
      4'h1: cond_pass = ~cpsr_q[FZ];
      4'h2: cond_pass = cpsr_q[FC];
      4'h3: cond_pass = ~cpsr_q[FC];
      4'h4: cond_pass = cpsr_q[FN];
      4'h5: cond_pass = ~cpsr_q[FN];
      4'h6: cond_pass = cpsr_q[FV];
      4'h7: cond_pass = ~cpsr_q[FV];
      4'h8: cond_pass = cpsr_q[FC] & ~cpsr_q[FZ];
      4'h9: cond_pass = ~cpsr_q[FC] | cpsr_q[FZ];
      4'hA: cond_pass = (cpsr_q[FN] == cpsr_q[FV]);
      4'hB: cond_pass = (cpsr_q[FN] != cpsr_q[FV]);
      4'hC: cond_pass = ~cpsr_q[FZ] & (cpsr_q[FN] == cpsr_q[FV]);
      4'hD: cond_pass = cpsr_q[FZ] | (cpsr_q[FN] != cpsr_q[FV]);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Barrel shifter; the extra bit in each wide vector captures the carry-out
  always_comb begin
    lsl_w = {1'b0, rm_in} << shiftby_in;
    lsr_w = {rm_in, 1'b0} >> shiftby_in;
    asr_w = $signed({rm_in, 1'b0}) >>> shiftby_in;
    ror_v = (rm_in >> shiftby_in) | (rm_in << (FULLW - 32'(shiftby_in)));
    op2   = rm_in;
    sh_c  = cpsr_q[FC];
    if (should_bypass_rm_in) begin
      op2 = bypass_rm_in;
    end else if (shiftby_in != '0) begin
      case (shiftcode_in)
        2'd0: begin op2 = lsl_w[FULLW-1:0]; sh_c = lsl_w[FULLW]; end
        2'd1: begin op2 = lsr_w[FULLW:1];   sh_c = lsr_w[0];     end
        2'd2: begin op2 = asr_w[FULLW:1];   sh_c = asr_w[0];     end
        default: begin op2 = ror_v;         sh_c = ror_v[MSB];   end
      endcase
    end
  end

  // Single adder; subtraction is a + ~b + cin so carry-out is NOT borrow
  always_comb begin
    add_a   = rn_in;
    add_b   = op2;
    add_cin = 1'b0;
    case (alu_opcode_in)
      OP_SUB, OP_CMP: begin add_b = ~op2; add_cin = 1'b1; end
      OP_RSB:         begin add_a = op2; add_b = ~rn_in; add_cin = 1'b1; end
      OP_ADC:         add_cin = cpsr_q[FC];
      OP_SBC:         begin add_b = ~op2; add_cin = cpsr_q[FC]; end
      OP_RSC:         begin add_a = op2; add_b = ~rn_in; add_cin = cpsr_q[FC]; end
      default:        ;
    endcase
    sum   = {1'b0, add_a} + {1'b0, add_b} + {{FULLW{1'b0}}, add_cin};
    add_v = (add_a[MSB] == add_b[MSB]) & (sum[MSB] != add_a[MSB]);
  end

  // Result select; logical ops take C from the shifter and keep V
  always_comb begin
    alu_res = sum[FULLW-1:0];
    alu_c   = sum[FULLW];
    alu_v   = add_v;
    case (alu_opcode_in)
      OP_AND, OP_TST: begin alu_res = rn_in & op2;  alu_c = sh_c; alu_v = cpsr_q[FV]; end
      OP_EOR, OP_TEQ: begin alu_res = rn_in ^ op2;  alu_c = sh_c; alu_v = cpsr_q[FV]; end
      OP_ORR:         begin alu_res = rn_in | op2;  alu_c = sh_c; alu_v = cpsr_q[FV]; end
      OP_MOV:         begin alu_res = op2;          alu_c = sh_c; alu_v = cpsr_q[FV]; end
      OP_BIC:         begin alu_res = rn_in & ~op2; alu_c = sh_c; alu_v = cpsr_q[FV]; end
      OP_MVN:         begin alu_res = ~op2;         alu_c = sh_c; alu_v = cpsr_q[FV]; end
      default:        ;
    endcase
  end

  // Next-state: commit gating, flags, branch, squash counter
  always_comb begin
    live      = ~is_invalid_in & (cnt_q == '0) & cond_pass;
    is_test   = (alu_opcode_in[3:2] == 2'b10);
    flags_new = {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
    result_d  = bl_in ? (pc_in + FULLW'(4)) : alu_res;
    wa_d      = bl_in ? LINK_REG : wa_in;
    reg_we_d  = live & (bl_in | (reg_we_in & ~is_test));
    mem_we_d  = live & mem_we_in;
    flush_d   = live & ib_in;
    target_d  = pc_in + FULLW'(8) + bv_in;
    cpsr_d    = live ? ((cpsr_q & ~should_set_cpsr_in) | (flags_new & should_set_cpsr_in))
                     : cpsr_q;
    cnt_d     = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNTW'(1);
    end else if (live & ib_in) begin
      cnt_d = CNTW'(SQUASH_N);
    end
  end

  // Stage registers; a stall holds everything including a pending flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q     <= '0;
      store_data_q <= '0;
      wa_q         <= '0;
      reg_we_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      byp_q        <= 1'b0;
      flush_q      <= 1'b0;
      target_q     <= '0;
      cpsr_q       <= '0;
      cnt_q        <= '0;
    end else if (!stall_in) begin
      result_q     <= result_d;
      store_data_q <= rd_in;
      wa_q         <= wa_d;
      reg_we_q     <= reg_we_d;
      mem_we_q     <= mem_we_d;
      byp_q        <= should_bypass_data_in;
      flush_q      <= flush_d;
      target_q     <= target_d;
      cpsr_q       <= cpsr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign result_out             = result_q;
  assign store_data_out         = store_data_q;
  assign wa_out                 = wa_q;
  assign reg_we_out             = reg_we_q;
  assign mem_we_out             = mem_we_q;
  assign should_bypass_data_out = byp_q;
  assign flush_out              = flush_q;
  assign branch_target_out      = target_q;
  assign cpsr_out               = cpsr_q;

endmodule

// File: tb/tb_stage_ex.sv
// Self-checking bench for stage_ex: directed scenarios plus randomized
// instructions checked against an arithmetic reference model.
module tb_stage_ex;
  localparam int unsigned FULLW    = 32;
  localparam int unsigned REGAW    = 4;
  localparam int          SQUASH_N = 2;

  typedef struct {
    logic [31:0] rn, rm, rd, bypv, bv, pc;
    logic        byp, ib, bl, rwe, mwe, bdata, inv;
    logic [1:0]  code;
    logic [4:0]  sh;
    logic [3:0]  opc, set, cond, wa;
  } instr_t;

  logic clk = 1'b0;
  logic rst_n;
  logic stall_in;
  logic [31:0] rn_in, rm_in, rd_in, bypass_rm_in, bv_in, pc_in;
  logic should_bypass_rm_in, ib_in, bl_in, reg_we_in, mem_we_in;
  logic should_bypass_data_in, is_invalid_in;
  logic [1:0] shiftcode_in;
  logic [4:0] shiftby_in;
  logic [3:0] alu_opcode_in, should_set_cpsr_in, cond_in, wa_in;
  logic [31:0] result_out, store_data_out, branch_target_out;
  logic [3:0] wa_out, cpsr_out;
  logic reg_we_out, mem_we_out, should_bypass_data_out, flush_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state and expected outputs
  logic [3:0]  m_cpsr;
  int          m_cnt;
  logic [31:0] e_result, e_store, e_target;
  logic [3:0]  e_wa, e_cpsr;
  logic        e_rwe, e_mwe, e_byp, e_flush;

  always #5 clk = ~clk;

  stage_ex #(.FULLW(FULLW), .REGAW(REGAW), .SQUASH_N(SQUASH_N)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
    .rn_in(rn_in), .rm_in(rm_in), .rd_in(rd_in),
    .bypass_rm_in(bypass_rm_in), .should_bypass_rm_in(should_bypass_rm_in),
    .shiftcode_in(shiftcode_in), .shiftby_in(shiftby_in),
    .alu_opcode_in(alu_opcode_in), .should_set_cpsr_in(should_set_cpsr_in),
    .cond_in(cond_in), .ib_in(ib_in), .bl_in(bl_in), .bv_in(bv_in), .pc_in(pc_in),
    .wa_in(wa_in), .reg_we_in(reg_we_in), .mem_we_in(mem_we_in),
    .should_bypass_data_in(should_bypass_data_in), .is_invalid_in(is_invalid_in),
    .result_out(result_out), .store_data_out(store_data_out), .wa_out(wa_out),
    .reg_we_out(reg_we_out), .mem_we_out(mem_we_out),
    .should_bypass_data_out(should_bypass_data_out), .flush_out(flush_out),
    .branch_target_out(branch_target_out), .cpsr_out(cpsr_out)
  );

  function automatic instr_t mk(input logic [3:0] opc, input logic [31:0] rn,
                                input logic [31:0] rm, input logic [3:0] set,
                                input logic [3:0] cond);
    instr_t t;
    t.rn = rn; t.rm = rm; t.rd = 32'h0; t.bypv = 32'h0; t.bv = 32'h0; t.pc = 32'h0;
    t.byp = 1'b0; t.ib = 1'b0; t.bl = 1'b0; t.rwe = 1'b1; t.mwe = 1'b0;
    t.bdata = 1'b0; t.inv = 1'b0; t.code = 2'd0; t.sh = 5'd0;
    t.opc = opc; t.set = set; t.cond = cond; t.wa = 4'd1;
    return t;
  endfunction

  function automatic instr_t nop();
    instr_t t;
    t = mk(4'h4, 32'h0, 32'h0, 4'h0, 4'hE);
    t.inv = 1'b1;
    return t;
  endfunction

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cc;         4'h3: return !cc;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cc && !z;   4'h9: return !cc || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic shift_model(input instr_t t, input logic cin,
                             output logic [31:0] op2, output logic sc);
    int n;
    longint s;
    n = int'(t.sh);
    op2 = t.rm; sc = cin;
    if (t.byp) begin
      op2 = t.bypv;
    end else if (n != 0) begin
      case (t.code)
        2'd0: begin op2 = t.rm << n; sc = t.rm[32-n]; end
        2'd1: begin op2 = t.rm >> n; sc = t.rm[n-1]; end
        2'd2: begin s = longint'($signed(t.rm)); s = s >>> n; op2 = s[31:0]; sc = t.rm[n-1]; end
        default: begin op2 = (t.rm >> n) | (t.rm << (32 - n)); sc = op2[31]; end
      endcase
    end
  endtask

  // Arithmetic done in 64-bit integers: C from unsigned range, V from signed range
  task automatic alu_model(input logic [3:0] op, input logic [31:0] rn, input logic [31:0] op2,
                           input logic sc, input logic [3:0] f,
                           output logic [31:0] res, output logic c, output logic v);
    longint ua, ub, sa, sb, full, sres, ci;
    ua = longint'({32'h0, rn}); ub = longint'({32'h0, op2});
    sa = longint'($signed(rn)); sb = longint'($signed(op2));
    ci = f[1] ? 64'sd1 : 64'sd0;
    full = 0; sres = 0;
    c = sc; v = f[0]; res = 32'h0;
    case (op)
      4'h0, 4'h8: res = rn & op2;
      4'h1, 4'h9: res = rn ^ op2;
      4'hC:       res = rn | op2;
      4'hD:       res = op2;
      4'hE:       res = rn & ~op2;
      4'hF:       res = ~op2;
      default: begin
        case (op)
          4'h4, 4'hB: begin full = ua + ub;           sres = sa + sb;           end
          4'h5:       begin full = ua + ub + ci;      sres = sa + sb + ci;      end
          4'h2, 4'hA: begin full = ua - ub;           sres = sa - sb;           end
          4'h6:       begin full = ua - ub - (1 - ci); sres = sa - sb - (1 - ci); end
          4'h3:       begin full = ub - ua;           sres = sb - sa;           end
          default:    begin full = ub - ua - (1 - ci); sres = sb - sa - (1 - ci); end
        endcase
        res = full[31:0];
        if (op == 4'h4 || op == 4'h5 || op == 4'hB) c = (full >= 64'sd4294967296);
        else c = (full >= 64'sd0);
        v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
    endcase
  endtask

  task automatic model_reset();
    m_cpsr = 4'h0; m_cnt = 0;
    e_result = 32'h0; e_store = 32'h0; e_target = 32'h0; e_wa = 4'h0; e_cpsr = 4'h0;
    e_rwe = 1'b0; e_mwe = 1'b0; e_byp = 1'b0; e_flush = 1'b0;
  endtask

  task automatic model_step(input instr_t t, input logic st);
    logic live, sc, c, v;
    logic [31:0] op2, res;
    logic [3:0] nf;
    if (!st) begin
      live = !t.inv && (m_cnt == 0) && cond_ok(t.cond, m_cpsr);
      shift_model(t, m_cpsr[1], op2, sc);
      alu_model(t.opc, t.rn, op2, sc, m_cpsr, res, c, v);
      nf = {res[31], res == 32'h0, c, v};
      e_result = t.bl ? t.pc + 32'd4 : res;
      e_wa     = t.bl ? 4'd14 : t.wa;
      e_rwe    = live && (t.bl || (t.rwe && !(t.opc >= 4'h8 && t.opc <= 4'hB)));
      e_mwe    = live && t.mwe;
      e_flush  = live && t.ib;
      e_target = t.pc + 32'd8 + t.bv;
      e_store  = t.rd;
      e_byp    = t.bdata;
      if (live) for (int i = 0; i < 4; i++) if (t.set[i]) m_cpsr[i] = nf[i];
      e_cpsr = m_cpsr;
      if (m_cnt > 0) m_cnt = m_cnt - 1;
      else if (live && t.ib) m_cnt = SQUASH_N;
    end
  endtask

  task automatic drive(input instr_t t, input logic st);
    stall_in = st;
    rn_in = t.rn; rm_in = t.rm; rd_in = t.rd; bypass_rm_in = t.bypv;
    should_bypass_rm_in = t.byp; shiftcode_in = t.code; shiftby_in = t.sh;
    alu_opcode_in = t.opc; should_set_cpsr_in = t.set; cond_in = t.cond;
    ib_in = t.ib; bl_in = t.bl; bv_in = t.bv; pc_in = t.pc; wa_in = t.wa;
    reg_we_in = t.rwe; mem_we_in = t.mwe; should_bypass_data_in = t.bdata;
    is_invalid_in = t.inv;
    model_step(t, st);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [107:0] got;
    rst_n = 1'b0;
    drive(nop(), 1'b0);
    drive(nop(), 1'b0);
    model_reset();
    got = {result_out, store_data_out, wa_out, reg_we_out, mem_we_out,
           should_bypass_data_out, flush_out, branch_target_out, cpsr_out};
    n_cmp++;
    if (got !== 108'h0) begin n_bad++; $display("FAIL reset_outputs got %h want 0", got); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_adds_overflow();
    drive(mk(4'h4, 32'h7FFF_FFFF, 32'h1, 4'hF, 4'hE), 1'b0);
    n_cmp++;
    if (result_out !== 32'h8000_0000) begin n_bad++; $display("FAIL adds_result got %h want 80000000", result_out); end
    n_cmp++;
    if (cpsr_out !== 4'b1001) begin n_bad++; $display("FAIL adds_cpsr got %b want 1001", cpsr_out); end
  endtask

  task automatic test_cond();
    drive(mk(4'h2, 32'd5, 32'd5, 4'hF, 4'hE), 1'b0);
    n_cmp++;
    if (cpsr_out !== 4'b0110) begin n_bad++; $display("FAIL subs_cpsr got %b want 0110", cpsr_out); end
    drive(mk(4'h4, 32'd1, 32'd2, 4'h0, 4'h0), 1'b0);
    n_cmp++;
    if (result_out !== 32'd3 || reg_we_out !== 1'b1) begin
      n_bad++; $display("FAIL addeq got res=%h we=%b want 3/1", result_out, reg_we_out);
    end
    drive(mk(4'h4, 32'd1, 32'd2, 4'hF, 4'h1), 1'b0);
    n_cmp++;
    if (reg_we_out !== 1'b0 || cpsr_out !== 4'b0110) begin
      n_bad++; $display("FAIL addne got we=%b cpsr=%b want 0/0110", reg_we_out, cpsr_out);
    end
  endtask

  task automatic test_shift();
    instr_t t;
    t = mk(4'hD, 32'h0, 32'h2, 4'b0010, 4'hE); t.code = 2'd1; t.sh = 5'd1;
    drive(t, 1'b0);
    n_cmp++;
    if (result_out !== 32'h1 || cpsr_out !== 4'b0100) begin
      n_bad++; $display("FAIL lsr1 got res=%h cpsr=%b want 1/0100", result_out, cpsr_out);
    end
    t = mk(4'hD, 32'h0, 32'h8000_0001, 4'b0010, 4'hE); t.code = 2'd3; t.sh = 5'd1;
    drive(t, 1'b0);
    n_cmp++;
    if (result_out !== 32'hC000_0000 || cpsr_out !== 4'b0110) begin
      n_bad++; $display("FAIL ror1 got res=%h cpsr=%b want c0000000/0110", result_out, cpsr_out);
    end
    t = mk(4'hD, 32'h0, 32'h8000_0001, 4'b0010, 4'hE);
    drive(t, 1'b0);
    n_cmp++;
    if (result_out !== 32'h8000_0001 || cpsr_out !== 4'b0110) begin
      n_bad++; $display("FAIL lsl0 got res=%h cpsr=%b want 80000001/0110", result_out, cpsr_out);
    end
  endtask

  task automatic test_branch();
    instr_t t;
    t = mk(4'h4, 32'h0, 32'h0, 4'h0, 4'hE);
    t.ib = 1'b1; t.rwe = 1'b0; t.pc = 32'h100; t.bv = 32'h20;
    drive(t, 1'b0);
    n_cmp++;
    if (flush_out !== 1'b1 || branch_target_out !== 32'h128) begin
      n_bad++; $display("FAIL b_flush got flush=%b tgt=%h want 1/128", flush_out, branch_target_out);
    end
    for (int i = 0; i < 3; i++) begin
      drive(mk(4'h4, 32'd7, 32'd8, 4'h0, 4'hE), 1'b0);
      n_cmp++;
      if (reg_we_out !== (i == 2) || flush_out !== 1'b0) begin
        n_bad++; $display("FAIL squash_%0d got we=%b flush=%b want %b/0", i, reg_we_out, flush_out, i == 2);
      end
    end
  endtask

  task automatic test_bl();
    instr_t t;
    t = mk(4'h4, 32'h0, 32'h0, 4'h0, 4'hE);
    t.ib = 1'b1; t.bl = 1'b1; t.rwe = 1'b0; t.pc = 32'h200; t.bv = 32'h40;
    drive(t, 1'b0);
    n_cmp++;
    if (result_out !== 32'h204 || wa_out !== 4'd14 || reg_we_out !== 1'b1 || flush_out !== 1'b1) begin
      n_bad++; $display("FAIL bl got res=%h wa=%0d we=%b flush=%b want 204/14/1/1",
                        result_out, wa_out, reg_we_out, flush_out);
    end
    drive(nop(), 1'b0);
    drive(nop(), 1'b0);
  endtask

  task automatic test_stall();
    instr_t t;
    drive(mk(4'h4, 32'h7FFF_FFFF, 32'h1, 4'hF, 4'hE), 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(mk(4'h4, 32'h0, 32'h0, 4'hF, 4'hE), 1'b1);
      n_cmp++;
      if (result_out !== 32'h8000_0000 || cpsr_out !== 4'b1001) begin
        n_bad++; $display("FAIL stall_hold_%0d got res=%h cpsr=%b want 80000000/1001", i, result_out, cpsr_out);
      end
    end
    t = mk(4'h4, 32'h0, 32'h0, 4'h0, 4'hE);
    t.ib = 1'b1; t.rwe = 1'b0; t.pc = 32'h300;
    drive(t, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(mk(4'h4, 32'h1, 32'h1, 4'h0, 4'hE), 1'b1);
      n_cmp++;
      if (flush_out !== 1'b1 || branch_target_out !== 32'h308) begin
        n_bad++; $display("FAIL stall_flush_%0d got flush=%b tgt=%h want 1/308", i, flush_out, branch_target_out);
      end
    end
    drive(mk(4'h4, 32'h1, 32'h1, 4'h0, 4'hE), 1'b0);
    n_cmp++;
    if (flush_out !== 1'b0 || reg_we_out !== 1'b0) begin
      n_bad++; $display("FAIL stall_release got flush=%b we=%b want 0/0", flush_out, reg_we_out);
    end
    drive(nop(), 1'b0);
    drive(nop(), 1'b0);
  endtask

  task automatic test_reset_mid_squash();
    instr_t t;
    logic [107:0] got;
    t = mk(4'h4, 32'h0, 32'h0, 4'h0, 4'hE);
    t.ib = 1'b1; t.rwe = 1'b0; t.pc = 32'h400;
    drive(t, 1'b0);
    t = mk(4'h4, 32'd10, 32'd20, 4'h0, 4'hE); t.wa = 4'd5;
    drive(t, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    got = {result_out, store_data_out, wa_out, reg_we_out, mem_we_out,
           should_bypass_data_out, flush_out, branch_target_out, cpsr_out};
    n_cmp++;
    if (got !== 108'h0) begin n_bad++; $display("FAIL midreset_outputs got %h want 0", got); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(t, 1'b0);
    n_cmp++;
    if (reg_we_out !== 1'b1 || result_out !== 32'd30 || wa_out !== 4'd5) begin
      n_bad++; $display("FAIL post_reset_add got we=%b res=%h wa=%0d want 1/1e/5", reg_we_out, result_out, wa_out);
    end
  endtask

  task automatic test_random();
    instr_t t;
    logic st;
    logic [107:0] got, exp;
    for (int k = 0; k < 400; k++) begin
      t = mk(4'($urandom), $urandom, $urandom, 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) == 0) t.rm = t.rn;
      if ($urandom_range(0, 1) == 0) t.cond = 4'hE;
      t.rd = $urandom; t.bypv = $urandom; t.bv = $urandom; t.pc = $urandom;
      t.byp = ($urandom_range(0, 3) == 0);
      t.code = 2'($urandom); t.sh = 5'($urandom);
      t.ib = ($urandom_range(0, 9) == 0);
      t.bl = t.ib && ($urandom_range(0, 1) == 0);
      t.rwe = 1'($urandom); t.mwe = 1'($urandom); t.bdata = 1'($urandom);
      t.inv = ($urandom_range(0, 7) == 0);
      t.wa = 4'($urandom);
      st = ($urandom_range(0, 4) == 0);
      drive(t, st);
      got = {result_out, store_data_out, wa_out, reg_we_out, mem_we_out,
             should_bypass_data_out, flush_out, branch_target_out, cpsr_out};
      exp = {e_result, e_store, e_wa, e_rwe, e_mwe, e_byp, e_flush, e_target, e_cpsr};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL random_%0d got %h want %h", k, got, exp);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_adds_overflow();
    test_cond();
    test_shift();
    test_branch();
    test_bl();
    test_stall();
    test_reset_mid_squash();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
